// File: rtl/math_multiply_pkg.sv
// Shared math package: the default operand width (shared with the divider)
// and the state encoding of the sequential multiply-accumulate unit.
package math_multiply_pkg;

  // Default operand width; the product is twice this.
  localparam int unsigned MATH_WIDTH = 32;

  // Control FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mul_state_e;

  // Counter width able to hold 0..width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : math_multiply_pkg

// File: rtl/math_multiply_if.sv
// Start/busy/done handshake and operand/result bus of math_multiply.
//   master : requester (drives start and operands, observes result)
//   slave  : the multiply unit
//   start        request, sampled only while the unit is not busy
//   Multiplicand unsigned operand A
//   Multiplier   unsigned operand B
//   Addend       unsigned accumulate term C (zero-extended)
//   product      A*B+C, 2*WIDTH bits
//   busy         high while iterating
//   done         one-cycle pulse when product becomes valid
interface math_multiply_if
  import math_multiply_pkg::*;
#(
  parameter int unsigned WIDTH = MATH_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic [WIDTH-1:0]     Addend;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;

  modport master (
    output start, Multiplicand, Multiplier, Addend,
    input  product, busy, done
  );

  modport slave (
    input  start, Multiplicand, Multiplier, Addend,
    output product, busy, done
  );

endinterface : math_multiply_if

// File: rtl/math_mul_step.sv
// One shift-add multiply iteration (purely combinational).
//   acc        running accumulator (2*WIDTH)
//   mcand_sr   multiplicand shift register (2*WIDTH), shifted left each step
//   mplier_sr  multiplier shift register (WIDTH), shifted right each step
//   *_c        next-iteration values
module math_mul_step
  import math_multiply_pkg::*;
#(
  parameter int unsigned WIDTH = MATH_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand_sr,
  input  logic [WIDTH-1:0]   mplier_sr,
  output logic [2*WIDTH-1:0] acc_c,
  output logic [2*WIDTH-1:0] mcand_c,
  output logic [WIDTH-1:0]   mplier_c
);

  // Add the aligned multiplicand when the current multiplier bit is set;
  // the result can never exceed 2*WIDTH bits, so the carry out is dropped.
  assign acc_c    = mplier_sr[0] ? (acc + mcand_sr) : acc;
  assign mcand_c  = mcand_sr << 1;
  assign mplier_c = mplier_sr >> 1;

endmodule : math_mul_step

// File: rtl/math_multiply.sv
// Sequential shift-add multiply-accumulate: product = A*B + C.
// Fixed latency of WIDTH iterations; done pulses for one cycle in the FIN
// state, during which a new start may be accepted back-to-back.
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    slave side of math_multiply_if (start/operands in, product/busy/done out)
module math_multiply
  import math_multiply_pkg::*;
#(
  parameter int unsigned WIDTH = MATH_WIDTH
) (
  input  logic           CLK,
  input  logic           RST_N,
  math_multiply_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mul_state_e      state_q,   state_n;
  logic [PW-1:0]   mcand_q,   mcand_n;
  logic [WIDTH-1:0] mplier_q, mplier_n;
  logic [PW-1:0]   acc_q,     acc_n;
  logic [CW-1:0]   count_q,   count_n;
  logic [PW-1:0]   product_q, product_n;
  logic            busy_q,    busy_n;
  logic            done_q,    done_n;

  logic [PW-1:0]    acc_step_c;
  logic [PW-1:0]    mcand_step_c;
  logic [WIDTH-1:0] mplier_step_c;

  // Datapath for one iteration.
  math_mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc       (acc_q),
    .mcand_sr  (mcand_q),
    .mplier_sr (mplier_q),
    .acc_c     (acc_step_c),
    .mcand_c   (mcand_step_c),
    .mplier_c  (mplier_step_c)
  );

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      mcand_q   <= mcand_n;
      mplier_q  <= mplier_n;
      acc_q     <= acc_n;
      count_q   <= count_n;
      product_q <= product_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  // Next-state, datapath update and registered-output decode.
  // busy/done are computed from the next state so they line up with it.
  always_comb begin
    state_n   = state_q;
    mcand_n   = mcand_q;
    mplier_n  = mplier_q;
    acc_n     = acc_q;
    count_n   = count_q;
    product_n = product_q;
    busy_n    = 1'b0;
    done_n    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_FIN: begin
        if (bus.start) begin
          mcand_n  = {{WIDTH{1'b0}}, bus.Multiplicand};
          mplier_n = bus.Multiplier;
          acc_n    = {{WIDTH{1'b0}}, bus.Addend};
          count_n  = '0;
          state_n  = ST_RUN;
          busy_n   = 1'b1;
        end else begin
          state_n  = ST_IDLE;
        end
      end

      ST_RUN: begin
        acc_n    = acc_step_c;
        mcand_n  = mcand_step_c;
        mplier_n = mplier_step_c;
        count_n  = count_q + CW'(1);
        // Last of exactly WIDTH iterations: publish the final sum.
        if (count_q == LAST_CNT) begin
          state_n   = ST_FIN;
          product_n = acc_step_c;
          done_n    = 1'b1;
        end else begin
          busy_n    = 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule : math_multiply
